// File: rtl/vec_pkg.sv
// Shared definitions for the vector write-back path.
//   VLEN / WORD_W   default register width and register-file port width
//   SEW_*           vsew encodings for 8/16/32/64-bit elements
//   wb_state_e      write-back sequencer states
//   vsew_legal()    true for the element-width encodings the lanes support
package vec_pkg;

    localparam int VLEN   = 128;
    localparam int WORD_W = 32;

    localparam logic [2:0] SEW_8  = 3'd0;
    localparam logic [2:0] SEW_16 = 3'd1;
    localparam logic [2:0] SEW_32 = 3'd2;
    localparam logic [2:0] SEW_64 = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_FIN
    } wb_state_e;

    function automatic logic vsew_legal(input logic [2:0] vsew);
        return vsew <= SEW_64;
    endfunction

endpackage

// File: rtl/vec_byte_strobe.sv
// Byte-enable generator for one 32-bit register-file word.
//   word_i    word index within the destination register
//   sew_i     element width encoding (legal values only, 0..3)
//   vl_eff_i  active element count, already clamped to the register capacity
//   vm_i      1 = unmasked, 0 = element i gated by mask_i[i]
//   mask_i    v0 contents
//   strb_o    one enable per byte of the word
// Disabled bytes leave the register file contents untouched, which is how
// both the tail and masked-off elements stay undisturbed.
module vec_byte_strobe
    import vec_pkg::*;
#(
    parameter int VLEN = vec_pkg::VLEN
) (
    input  logic [3:0]      word_i,
    input  logic [1:0]      sew_i,
    input  logic [9:0]      vl_eff_i,
    input  logic            vm_i,
    input  logic [VLEN-1:0] mask_i,
    output logic [3:0]      strb_o
);

    logic [9:0] gbyte;
    logic [9:0] elem;

    always_comb begin
        strb_o = '0;
        gbyte  = '0;
        elem   = '0;
        for (int b = 0; b < 4; b++) begin
            gbyte     = {4'd0, word_i, 2'(b)};
            // Element index is the global byte index divided by the element size.
            elem      = gbyte >> sew_i;
            strb_o[b] = (elem < vl_eff_i) && (vm_i || mask_i[elem]);
        end
    end

endmodule

// File: rtl/vec_wb_sequencer.sv
// Vector write-back sequencer: latches a completed VLEN-bit ALU result and
// writes it to the vector register file one 32-bit word per cycle.
//   clk, resetn            clock (rising edge), asynchronous active-low reset
//   start                  one-cycle request, operands valid in that cycle
//   vd_idx, result         destination register and result vector
//   vsew, vl, vm, mask     element width, active length, mask enable, v0
//   rf_ready               register file accepts the current beat
//   rf_we, rf_waddr, rf_wword, rf_wdata, rf_wstrb   write port (combinational)
//   busy, done, err        registered status back to the vector sequencer
module vec_wb_sequencer #(
    parameter int VLEN = vec_pkg::VLEN
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [4:0]      vd_idx,
    input  logic [VLEN-1:0] result,
    input  logic [2:0]      vsew,
    input  logic [9:0]      vl,
    input  logic            vm,
    input  logic [VLEN-1:0] mask,
    input  logic            rf_ready,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [3:0]      rf_wword,
    output logic [31:0]     rf_wdata,
    output logic [3:0]      rf_wstrb,
    output logic            busy,
    output logic            done,
    output logic            err
);
    import vec_pkg::*;

    localparam int NWORDS = VLEN / WORD_W;

    wb_state_e       state_q, state_d;
    logic [3:0]      word_q, word_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            latch_en;

    logic [4:0]      vd_q;
    logic [VLEN-1:0] result_q;
    logic [1:0]      sew_q;
    logic [9:0]      vl_q;
    logic            vm_q;
    logic [VLEN-1:0] mask_q;

    logic [10:0]     vl_cap;
    logic [9:0]      vl_eff;
    logic [3:0]      strb;
    logic            in_write;

    // Elements beyond what fits in one register are never written.
    always_comb begin
        vl_cap = 11'((VLEN / 8) >> sew_q);
        vl_eff = ({1'b0, vl_q} < vl_cap) ? vl_q : vl_cap[9:0];
    end

    vec_byte_strobe #(
        .VLEN(VLEN)
    ) u_strobe (
        .word_i  (word_q),
        .sew_i   (sew_q),
        .vl_eff_i(vl_eff),
        .vm_i    (vm_q),
        .mask_i  (mask_q),
        .strb_o  (strb)
    );

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        err_d    = err_q;
        latch_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    latch_en = 1'b1;
                    word_d   = '0;
                    err_d    = !vsew_legal(vsew);
                    state_d  = vsew_legal(vsew) ? ST_WRITE : ST_FIN;
                end
            end
            ST_WRITE: begin
                // An all-zero strobe word is skipped without a write request.
                if ((strb == 4'd0) || rf_ready) begin
                    if (word_q == 4'(NWORDS - 1)) begin
                        state_d = ST_FIN;
                    end else begin
                        word_d = word_q + 4'd1;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_WRITE);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            word_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            vd_q     <= '0;
            result_q <= '0;
            sew_q    <= '0;
            vl_q     <= '0;
            vm_q     <= 1'b0;
            mask_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (latch_en) begin
                vd_q     <= vd_idx;
                result_q <= result;
                sew_q    <= vsew[1:0];
                vl_q     <= vl;
                vm_q     <= vm;
                mask_q   <= mask;
            end
        end
    end

    // Write port depends only on registered state, so it holds through stalls.
    assign in_write = (state_q == ST_WRITE);
    assign rf_we    = in_write && (strb != 4'd0);
    assign rf_waddr = in_write ? vd_q : '0;
    assign rf_wword = in_write ? word_q : '0;
    assign rf_wdata = in_write ? result_q[word_q*WORD_W +: WORD_W] : '0;
    assign rf_wstrb = in_write ? strb : '0;

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_vec_wb_sequencer.sv
module tb_vec_wb_sequencer;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [4:0]   vd_idx;
    logic [127:0] result;
    logic [2:0]   vsew;
    logic [9:0]   vl;
    logic         vm;
    logic [127:0] mask;
    logic         rf_ready;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [3:0]   rf_wword;
    logic [31:0]  rf_wdata;
    logic [3:0]   rf_wstrb;
    logic         busy;
    logic         done;
    logic         err;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_word [4];
    logic [4:0]  exp_vd;

    vec_wb_sequencer #(.VLEN(128)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .vd_idx  (vd_idx),
        .result  (result),
        .vsew    (vsew),
        .vl      (vl),
        .vm      (vm),
        .mask    (mask),
        .rf_ready(rf_ready),
        .rf_we   (rf_we),
        .rf_waddr(rf_waddr),
        .rf_wword(rf_wword),
        .rf_wdata(rf_wdata),
        .rf_wstrb(rf_wstrb),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check one cycle; write-port contents are only checked on a write beat.
    task automatic cyc(input string tag, input logic we, input logic [3:0] wword,
                       input logic [3:0] wstrb, input logic bsy, input logic dn);
        chk({tag, ".we"}, 32'(rf_we), 32'(we));
        chk({tag, ".busy"}, 32'(busy), 32'(bsy));
        chk({tag, ".done"}, 32'(done), 32'(dn));
        if (we) begin
            chk({tag, ".wword"}, 32'(rf_wword), 32'(wword));
            chk({tag, ".wstrb"}, 32'(rf_wstrb), 32'(wstrb));
            chk({tag, ".wdata"}, rf_wdata, exp_word[wword[1:0]]);
            chk({tag, ".waddr"}, 32'(rf_waddr), 32'(exp_vd));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start; returns sampled in cycle 1 after the start edge.
    task automatic go(input logic [4:0] vd, input logic [2:0] sew, input logic [9:0] len,
                      input logic m, input logic [127:0] msk);
        vd_idx = vd;
        vsew   = sew;
        vl     = len;
        vm     = m;
        mask   = msk;
        result = {exp_word[3], exp_word[2], exp_word[1], exp_word[0]};
        exp_vd = vd;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    initial begin
        exp_word[0] = 32'h0123_4567;
        exp_word[1] = 32'h89AB_CDEF;
        exp_word[2] = 32'hDEAD_BEEF;
        exp_word[3] = 32'hCAFE_F00D;
        exp_vd   = '0;
        resetn   = 1'b0;
        start    = 1'b0;
        vd_idx   = '0;
        result   = '0;
        vsew     = '0;
        vl       = '0;
        vm       = 1'b1;
        mask     = '0;
        rf_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("rst.we", 32'(rf_we), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.wdata", rf_wdata, 32'd0);
        chk("rst.wstrb", 32'(rf_wstrb), 32'd0);
        #2 resetn = 1'b1;
        step();

        // 32-bit elements, all active; a start mid-transfer is ignored
        go(5'd7, 3'd2, 10'd4, 1'b1, '0);
        cyc("t1.c1", 1, 4'd0, 4'hF, 1, 0);
        step();
        cyc("t1.c2", 1, 4'd1, 4'hF, 1, 0);
        vd_idx = 5'd9;
        vsew   = 3'd5;
        result = '0;
        start  = 1'b1;
        step();
        start  = 1'b0;
        cyc("t1.c3", 1, 4'd2, 4'hF, 1, 0);
        step();
        cyc("t1.c4", 1, 4'd3, 4'hF, 1, 0);
        step();
        cyc("t1.c5", 0, 4'd0, 4'h0, 0, 1);
        chk("t1.err", 32'(err), 32'd0);
        step();
        cyc("t1.c6", 0, 4'd0, 4'h0, 0, 0);

        // 8-bit elements, vl=5: tail words skipped
        go(5'd3, 3'd0, 10'd5, 1'b1, '0);
        cyc("t2.c1", 1, 4'd0, 4'hF, 1, 0);
        step();
        cyc("t2.c2", 1, 4'd1, 4'h1, 1, 0);
        step();
        cyc("t2.c3", 0, 4'd0, 4'h0, 1, 0);
        step();
        cyc("t2.c4", 0, 4'd0, 4'h0, 1, 0);
        step();
        cyc("t2.c5", 0, 4'd0, 4'h0, 0, 1);
        step();

        // 16-bit elements masked by v0 = ...0101
        go(5'd12, 3'd1, 10'd8, 1'b0, 128'h5);
        cyc("t3.c1", 1, 4'd0, 4'h3, 1, 0);
        step();
        cyc("t3.c2", 1, 4'd1, 4'h3, 1, 0);
        step();
        cyc("t3.c3", 0, 4'd0, 4'h0, 1, 0);
        step();
        cyc("t3.c4", 0, 4'd0, 4'h0, 1, 0);
        step();
        cyc("t3.c5", 0, 4'd0, 4'h0, 0, 1);
        step();

        // 64-bit elements, vl=2, three stalled edges on beat 0
        rf_ready = 1'b0;
        go(5'd31, 3'd3, 10'd2, 1'b1, '0);
        cyc("t4.s1", 1, 4'd0, 4'hF, 1, 0);
        step();
        cyc("t4.s2", 1, 4'd0, 4'hF, 1, 0);
        step();
        cyc("t4.s3", 1, 4'd0, 4'hF, 1, 0);
        step();
        cyc("t4.s4", 1, 4'd0, 4'hF, 1, 0);
        rf_ready = 1'b1;
        step();
        cyc("t4.b1", 1, 4'd1, 4'hF, 1, 0);
        step();
        cyc("t4.b2", 1, 4'd2, 4'hF, 1, 0);
        step();
        cyc("t4.b3", 1, 4'd3, 4'hF, 1, 0);
        step();
        cyc("t4.fin", 0, 4'd0, 4'h0, 0, 1);
        step();

        // Illegal vsew: no writes, error flag, immediate completion
        go(5'd4, 3'd5, 10'd4, 1'b1, '0);
        cyc("t5.c1", 0, 4'd0, 4'h0, 0, 1);
        chk("t5.err1", 32'(err), 32'd1);
        step();
        cyc("t5.c2", 0, 4'd0, 4'h0, 0, 0);
        chk("t5.err2", 32'(err), 32'd1);
        step();

        // Legal start clears err; reset during word 2 abandons the transfer
        go(5'd20, 3'd2, 10'd4, 1'b1, '0);
        cyc("t6.c1", 1, 4'd0, 4'hF, 1, 0);
        chk("t6.errclr", 32'(err), 32'd0);
        step();
        cyc("t6.c2", 1, 4'd1, 4'hF, 1, 0);
        step();
        cyc("t6.c3", 1, 4'd2, 4'hF, 1, 0);
        resetn = 1'b0;
        #1;
        chk("t6.rst.we", 32'(rf_we), 32'd0);
        chk("t6.rst.busy", 32'(busy), 32'd0);
        chk("t6.rst.wdata", rf_wdata, 32'd0);
        chk("t6.rst.waddr", 32'(rf_waddr), 32'd0);
        chk("t6.rst.done", 32'(done), 32'd0);
        step();
        #2 resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            cyc("t6.idle", 0, 4'd0, 4'h0, 0, 0);
        end

        // Fresh start after reset completes normally
        go(5'd21, 3'd2, 10'd4, 1'b1, '0);
        for (int k = 0; k < 4; k++) begin
            cyc("t6.b", 1, 4'(k), 4'hF, 1, 0);
            step();
        end
        cyc("t6.fin", 0, 4'd0, 4'h0, 0, 1);
        step();
        cyc("t6.post", 0, 4'd0, 4'h0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
